// File: rtl/adc_lvds_tx_emulator_if.sv
// ============================================================================
// Module : adc_lvds_tx_emulator_if
// Brief  : Dual-channel AXI-stream sample bus feeding the LVDS TX emulator.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface adc_lvds_tx_emulator_if;
  logic        s_axis_tvalid_chA;
  logic        s_axis_tready_chA;
  logic [15:0] s_axis_tdata_chA;
  logic        s_axis_tvalid_chB;
  logic        s_axis_tready_chB;
  logic [15:0] s_axis_tdata_chB;

  modport master (
    output s_axis_tvalid_chA, s_axis_tdata_chA,
    output s_axis_tvalid_chB, s_axis_tdata_chB,
    input  s_axis_tready_chA, s_axis_tready_chB
  );

  modport slave (
    input  s_axis_tvalid_chA, s_axis_tdata_chA,
    input  s_axis_tvalid_chB, s_axis_tdata_chB,
    output s_axis_tready_chA, s_axis_tready_chB
  );
endinterface

`default_nettype wire

// File: rtl/adc_lvds_tx_emulator.sv
// ============================================================================
// Module : adc_lvds_tx_emulator
// Brief  : AD9643-style LVDS output emulator (stream FIFOs or test patterns).
//          Optional macro ADC_TX_OFFSET_BIN_EN selects offset-binary words.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module adc_lvds_tx_emulator #(
  parameter int DATA_WIDTH = 14,
  parameter int FIFO_DEPTH = 8
) (
  input  wire logic                  s_axis_aclk,
  input  wire logic                  s_axis_aresetn,
  input  wire logic                  enable,
  input  wire logic [1:0]            mode,
  adc_lvds_tx_emulator_if.slave      s_axis,
  output logic      [DATA_WIDTH-1:0] data_rise,
  output logic      [DATA_WIDTH-1:0] data_fall,
  output logic                       or_rise,
  output logic                       or_fall,
  output logic                       tx_valid,
  input  wire logic                  underrun_clr,
  output logic      [15:0]           underrun_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] MODE_STREAM  = 2'd0;
  localparam logic [1:0] MODE_COUNTER = 2'd1;
  localparam logic [1:0] MODE_TOGGLE  = 2'd2;
  localparam logic [1:0] MODE_MID     = 2'd3;

`ifdef ADC_TX_OFFSET_BIN_EN
  localparam logic [DATA_WIDTH-1:0] OB_MASK = DATA_WIDTH'(1) << (DATA_WIDTH - 1);
`else
  localparam logic [DATA_WIDTH-1:0] OB_MASK = '0;
`endif

  localparam logic [DATA_WIDTH-1:0] IDLE_WORD = OB_MASK;
  localparam logic [DATA_WIDTH-1:0] C_ONE     = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] C_TWO     = DATA_WIDTH'(2);
  localparam logic [AW:0]           PTR_ONE   = (AW + 1)'(1);
  localparam int                    SAT_MAX   = (1 << (DATA_WIDTH - 1)) - 1;
  localparam int                    SAT_MIN   = -(1 << (DATA_WIDTH - 1));

  // Alternating bit pattern: odd=1 sets bits 1,3,5.. (0x2AAA at 14 bits).
  function automatic logic [DATA_WIDTH-1:0] alt_bits(input logic odd);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      r[i] = ((i % 2) == 1) ? odd : ~odd;
    end
    return r;
  endfunction

  localparam logic [DATA_WIDTH-1:0] TOG_RISE = alt_bits(1'b1);
  localparam logic [DATA_WIDTH-1:0] TOG_FALL = alt_bits(1'b0);

  // Returns {clip_flag, output_word} for one 16-bit signed sample.
  function automatic logic [DATA_WIDTH:0] sat_word(input logic [15:0] s);
    int          v;
    logic [31:0] u;
    logic        clip;
    v    = int'($signed(s));
    clip = 1'b0;
    if (v > SAT_MAX) begin
      v    = SAT_MAX;
      clip = 1'b1;
    end else if (v < SAT_MIN) begin
      v    = SAT_MIN;
      clip = 1'b1;
    end
    u = v;
    return {clip, u[DATA_WIDTH-1:0] ^ OB_MASK};
  endfunction

  logic [15:0]           mem_a_q [FIFO_DEPTH];
  logic [15:0]           mem_b_q [FIFO_DEPTH];
  logic [AW:0]           wr_a_q, rd_a_q, wr_b_q, rd_b_q;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rise_q, rise_d, fall_q, fall_d;
  logic                  or_rise_q, or_rise_d, or_fall_q, or_fall_d;
  logic                  valid_q, valid_d;
  logic [15:0]           urun_q, urun_d;

  logic                  stream_on;
  logic                  empty_a, empty_b, full_a, full_b;
  logic                  push_a, push_b, pop;
  logic [DATA_WIDTH:0]   sat_a, sat_b;

  assign stream_on = enable && (mode == MODE_STREAM);
  assign empty_a   = (wr_a_q == rd_a_q);
  assign empty_b   = (wr_b_q == rd_b_q);
  assign full_a    = (wr_a_q[AW] != rd_a_q[AW]) && (wr_a_q[AW-1:0] == rd_a_q[AW-1:0]);
  assign full_b    = (wr_b_q[AW] != rd_b_q[AW]) && (wr_b_q[AW-1:0] == rd_b_q[AW-1:0]);

  // Gated by reset so ready reads low while the block is held in reset.
  assign s_axis.s_axis_tready_chA = s_axis_aresetn && stream_on && !full_a;
  assign s_axis.s_axis_tready_chB = s_axis_aresetn && stream_on && !full_b;

  assign push_a = s_axis.s_axis_tvalid_chA && s_axis.s_axis_tready_chA;
  assign push_b = s_axis.s_axis_tvalid_chB && s_axis.s_axis_tready_chB;

  assign sat_a = sat_word(mem_a_q[rd_a_q[AW-1:0]]);
  assign sat_b = sat_word(mem_b_q[rd_b_q[AW-1:0]]);

  always_comb begin
    rise_d    = IDLE_WORD;
    fall_d    = IDLE_WORD;
    or_rise_d = 1'b0;
    or_fall_d = 1'b0;
    valid_d   = 1'b0;
    cnt_d     = '0;
    pop       = 1'b0;
    urun_d    = urun_q;
    if (enable) begin
      case (mode)
        MODE_STREAM: begin
          if (!empty_a && !empty_b) begin
            pop       = 1'b1;
            rise_d    = sat_a[DATA_WIDTH-1:0];
            fall_d    = sat_b[DATA_WIDTH-1:0];
            or_rise_d = sat_a[DATA_WIDTH];
            or_fall_d = sat_b[DATA_WIDTH];
            valid_d   = 1'b1;
          end else if (urun_q != 16'hFFFF) begin
            urun_d = urun_q + 16'd1;
          end
        end
        MODE_COUNTER: begin
          rise_d  = cnt_q ^ OB_MASK;
          fall_d  = (cnt_q + C_ONE) ^ OB_MASK;
          cnt_d   = cnt_q + C_TWO;
          valid_d = 1'b1;
        end
        MODE_TOGGLE: begin
          rise_d  = TOG_RISE ^ OB_MASK;
          fall_d  = TOG_FALL ^ OB_MASK;
          valid_d = 1'b1;
        end
        MODE_MID: begin
          valid_d = 1'b1;
        end
        default: begin
          valid_d = 1'b0;
        end
      endcase
    end
    if (underrun_clr) begin
      urun_d = '0;
    end
  end

  // Sample storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge s_axis_aclk) begin
    if (push_a) mem_a_q[wr_a_q[AW-1:0]] <= s_axis.s_axis_tdata_chA;
    if (push_b) mem_b_q[wr_b_q[AW-1:0]] <= s_axis.s_axis_tdata_chB;
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      wr_a_q <= '0;
      rd_a_q <= '0;
      wr_b_q <= '0;
      rd_b_q <= '0;
    end else if (!stream_on) begin
      wr_a_q <= '0;
      rd_a_q <= '0;
      wr_b_q <= '0;
      rd_b_q <= '0;
    end else begin
      if (push_a) wr_a_q <= wr_a_q + PTR_ONE;
      if (push_b) wr_b_q <= wr_b_q + PTR_ONE;
      if (pop) begin
        rd_a_q <= rd_a_q + PTR_ONE;
        rd_b_q <= rd_b_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      cnt_q     <= '0;
      rise_q    <= IDLE_WORD;
      fall_q    <= IDLE_WORD;
      or_rise_q <= 1'b0;
      or_fall_q <= 1'b0;
      valid_q   <= 1'b0;
      urun_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      or_rise_q <= or_rise_d;
      or_fall_q <= or_fall_d;
      valid_q   <= valid_d;
      urun_q    <= urun_d;
    end
  end

  assign data_rise    = rise_q;
  assign data_fall    = fall_q;
  assign or_rise      = or_rise_q;
  assign or_fall      = or_fall_q;
  assign tx_valid     = valid_q;
  assign underrun_cnt = urun_q;

endmodule

`default_nettype wire

// File: tb/tb_adc_lvds_tx_emulator.sv
// ============================================================================
// Module : tb_adc_lvds_tx_emulator
// Brief  : Directed self-checking bench for adc_lvds_tx_emulator.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_adc_lvds_tx_emulator;

`ifdef ADC_TX_OFFSET_BIN_EN
  localparam logic [13:0] OB = 14'h2000;
`else
  localparam logic [13:0] OB = 14'h0000;
`endif

  logic        clk          = 1'b0;
  logic        rst_n        = 1'b0;
  logic        enable       = 1'b0;
  logic [1:0]  mode         = 2'd0;
  logic        underrun_clr = 1'b0;
  logic [13:0] data_rise, data_fall;
  logic        or_rise, or_fall, tx_valid;
  logic [15:0] underrun_cnt;
  int          tests = 0;
  int          fails = 0;

  adc_lvds_tx_emulator_if bus ();

  adc_lvds_tx_emulator #(.DATA_WIDTH(14), .FIFO_DEPTH(8)) dut (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (rst_n),
    .enable         (enable),
    .mode           (mode),
    .s_axis         (bus.slave),
    .data_rise      (data_rise),
    .data_fall      (data_fall),
    .or_rise        (or_rise),
    .or_fall        (or_fall),
    .tx_valid       (tx_valid),
    .underrun_clr   (underrun_clr),
    .underrun_cnt   (underrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.s_axis_tvalid_chA = 1'b0;
    bus.s_axis_tvalid_chB = 1'b0;
    bus.s_axis_tdata_chA  = 16'h0;
    bus.s_axis_tdata_chB  = 16'h0;

    // Reset state
    #2;
    chk("rst_rise", data_rise, OB);
    chk("rst_fall", data_fall, OB);
    chk("rst_or", {or_rise, or_fall}, 0);
    chk("rst_valid", tx_valid, 0);
    chk("rst_urun", underrun_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Counter mode and 14-bit wrap
    mode = 2'd1; enable = 1'b1;
    tick();
    chk("cnt0_rise", data_rise, 14'h0000 ^ OB);
    chk("cnt0_fall", data_fall, 14'h0001 ^ OB);
    chk("cnt0_valid", tx_valid, 1);
    tick();
    chk("cnt1_rise", data_rise, 14'h0002 ^ OB);
    chk("cnt1_fall", data_fall, 14'h0003 ^ OB);
    repeat (8190) tick();
    chk("cnt_top_rise", data_rise, 14'h3FFE ^ OB);
    chk("cnt_top_fall", data_fall, 14'h3FFF ^ OB);
    tick();
    chk("cnt_wrap_rise", data_rise, 14'h0000 ^ OB);
    chk("cnt_wrap_fall", data_fall, 14'h0001 ^ OB);

    // Disabled output
    enable = 1'b0;
    tick();
    chk("dis_rise", data_rise, OB);
    chk("dis_valid", tx_valid, 0);

    // Stream mode, in-range samples
    mode = 2'd0; enable = 1'b1; underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    chk("clr_urun", underrun_cnt, 0);
    chk("rdy_a_on", bus.s_axis_tready_chA, 1);
    bus.s_axis_tvalid_chA = 1'b1; bus.s_axis_tdata_chA = 16'd100;
    bus.s_axis_tvalid_chB = 1'b1; bus.s_axis_tdata_chB = 16'hFF9C;
    tick();
    bus.s_axis_tvalid_chA = 1'b0; bus.s_axis_tvalid_chB = 1'b0;
    tick();
    chk("s1_rise", data_rise, 14'h0064 ^ OB);
    chk("s1_fall", data_fall, 14'h3F9C ^ OB);
    chk("s1_or", {or_rise, or_fall}, 0);
    chk("s1_valid", tx_valid, 1);
    chk("s1_urun", underrun_cnt, 1);

    // Clipping on both channels
    bus.s_axis_tvalid_chA = 1'b1; bus.s_axis_tdata_chA = 16'h2100;
    bus.s_axis_tvalid_chB = 1'b1; bus.s_axis_tdata_chB = 16'hC000;
    tick();
    bus.s_axis_tvalid_chA = 1'b0; bus.s_axis_tvalid_chB = 1'b0;
    tick();
    chk("clip_rise", data_rise, 14'h1FFF ^ OB);
    chk("clip_or_rise", or_rise, 1);
    chk("clip_fall", data_fall, 14'h2000 ^ OB);
    chk("clip_or_fall", or_fall, 1);

    // Exact range limits do not clip
    bus.s_axis_tvalid_chA = 1'b1; bus.s_axis_tdata_chA = 16'h1FFF;
    bus.s_axis_tvalid_chB = 1'b1; bus.s_axis_tdata_chB = 16'hE000;
    tick();
    bus.s_axis_tvalid_chA = 1'b0; bus.s_axis_tvalid_chB = 1'b0;
    tick();
    chk("lim_rise", data_rise, 14'h1FFF ^ OB);
    chk("lim_fall", data_fall, 14'h2000 ^ OB);
    chk("lim_or", {or_rise, or_fall}, 0);

    // Underrun: chA holds 3 samples, chB empty, clear has priority
    underrun_clr = 1'b1;
    bus.s_axis_tvalid_chA = 1'b1;
    bus.s_axis_tdata_chA = 16'd1; tick();
    bus.s_axis_tdata_chA = 16'd2; tick();
    bus.s_axis_tdata_chA = 16'd3; tick();
    bus.s_axis_tvalid_chA = 1'b0;
    chk("urun_clr_prio", underrun_cnt, 0);
    underrun_clr = 1'b0;
    repeat (10) tick();
    chk("urun_cnt10", underrun_cnt, 10);
    chk("urun_valid", tx_valid, 0);
    chk("urun_rise", data_rise, OB);
    chk("urun_or", {or_rise, or_fall}, 0);
    bus.s_axis_tvalid_chB = 1'b1; bus.s_axis_tdata_chB = 16'hFFFF; tick();
    bus.s_axis_tdata_chB = 16'hFFFE; tick();
    chk("ord1_rise", data_rise, 14'h0001 ^ OB);
    chk("ord1_fall", data_fall, 14'h3FFF ^ OB);
    bus.s_axis_tdata_chB = 16'hFFFD; tick();
    bus.s_axis_tvalid_chB = 1'b0;
    chk("ord2_rise", data_rise, 14'h0002 ^ OB);
    chk("ord2_fall", data_fall, 14'h3FFE ^ OB);
    tick();
    chk("ord3_rise", data_rise, 14'h0003 ^ OB);
    chk("ord3_fall", data_fall, 14'h3FFD ^ OB);
    chk("ord3_valid", tx_valid, 1);
    tick();
    chk("ord_end_valid", tx_valid, 0);
    chk("ord_end_urun", underrun_cnt, 12);

    // Fill chA, then toggle mode flushes
    bus.s_axis_tvalid_chA = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.s_axis_tdata_chA = 16'(i + 16);
      tick();
    end
    bus.s_axis_tvalid_chA = 1'b0;
    chk("full_rdy_a", bus.s_axis_tready_chA, 0);
    chk("full_rdy_b", bus.s_axis_tready_chB, 1);
    mode = 2'd2;
    tick();
    chk("tog_rise", data_rise, 14'h2AAA ^ OB);
    chk("tog_fall", data_fall, 14'h1555 ^ OB);
    chk("tog_valid", tx_valid, 1);
    chk("tog_rdy_a", bus.s_axis_tready_chA, 0);
    mode = 2'd0;
    tick();
    chk("flush_rdy_a", bus.s_axis_tready_chA, 1);
    bus.s_axis_tvalid_chB = 1'b1; bus.s_axis_tdata_chB = 16'd5; tick();
    bus.s_axis_tvalid_chB = 1'b0;
    tick();
    chk("flush_valid", tx_valid, 0);

    // Midscale
    mode = 2'd3;
    tick();
    chk("mid_rise", data_rise, OB);
    chk("mid_fall", data_fall, OB);
    chk("mid_valid", tx_valid, 1);

    // Asynchronous reset mid-operation discards FIFO contents
    mode = 2'd0;
    tick();
    bus.s_axis_tvalid_chA = 1'b1; bus.s_axis_tdata_chA = 16'd7; tick();
    bus.s_axis_tvalid_chA = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_urun", underrun_cnt, 0);
    chk("arst_rdy_a", bus.s_axis_tready_chA, 0);
    chk("arst_rise", data_rise, OB);
    tick();
    rst_n = 1'b1;
    bus.s_axis_tvalid_chB = 1'b1; bus.s_axis_tdata_chB = 16'd4; tick();
    bus.s_axis_tvalid_chB = 1'b0;
    tick();
    chk("arst_fifo_empty", tx_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
